// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch / load-store memory port arbiter:
// FSM state encoding, requester ids and latency defaults.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_t;

    localparam int DEFAULT_RD_LAT = 2;

    // Wide enough for the largest supported read latency of 7.
    localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and the load/store path; one access in flight, registered memory outputs.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = DEFAULT_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              proto_err
);

    arb_state_t           state;
    req_id_t              last;
    req_id_t              cur_req;
    logic                 cur_write;
    logic [LAT_CNT_W-1:0] lat_cnt;

    logic fetch_pend;
    logic data_pend;
    logic pick_data;

    // Data wins only when fetch is idle or fetch had the previous grant.
    assign fetch_pend = if_req;
    assign data_pend  = dm_rd | dm_wr;
    assign pick_data  = data_pend && (!fetch_pend || (last == REQ_FETCH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= REQ_DATA;
            cur_req   <= REQ_FETCH;
            cur_write <= 1'b0;
            lat_cnt   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (fetch_pend || data_pend) begin
                        if (pick_data) begin
                            cur_req   <= REQ_DATA;
                            last      <= REQ_DATA;
                            cur_write <= dm_wr;
                            mem_we    <= dm_wr;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            // A simultaneous read+write is resolved as a write.
                            if (dm_rd && dm_wr) begin
                                proto_err <= 1'b1;
                            end
                        end else begin
                            cur_req   <= REQ_FETCH;
                            last      <= REQ_FETCH;
                            cur_write <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                        end
                        mem_en <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ISSUE;
                    end
                end

                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (cur_write || (RD_LAT == 1)) begin
                        if (!cur_write) begin
                            if (cur_req == REQ_FETCH) begin
                                if_rdata <= mem_rdata;
                            end else begin
                                dm_rdata <= mem_rdata;
                            end
                        end
                        if (cur_req == REQ_FETCH) begin
                            if_done <= 1'b1;
                        end else begin
                            dm_done <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        lat_cnt <= LAT_CNT_W'(RD_LAT - 1);
                        state   <= WAIT;
                    end
                end

                WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    // The final count step coincides with valid memory data.
                    if (lat_cnt == LAT_CNT_W'(1)) begin
                        if (cur_req == REQ_FETCH) begin
                            if_rdata <= mem_rdata;
                            if_done  <= 1'b1;
                        end else begin
                            dm_rdata <= mem_rdata;
                            dm_done  <= 1'b1;
                        end
                        state <= DONE;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions push expected
// completions; a negedge monitor pops and compares every done pulse.
module tb_mem_port_arbiter;

    typedef struct {
        logic        req;
        logic [31:0] data;
        logic        chk;
        int          at;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [9:0]  if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_rd;
    logic        dm_wr;
    logic [9:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        proto_err;

    logic        if_req1;
    logic [9:0]  if_addr1;
    logic [31:0] if_rdata1;
    logic        if_done1;
    logic [31:0] dm_rdata1;
    logic        dm_done1;
    logic        mem_en1;
    logic        mem_we1;
    logic [9:0]  mem_addr1;
    logic [31:0] mem_wdata1;
    logic [31:0] mem_rdata1;
    logic        busy1;
    logic        proto_err1;

    logic        if_req4;
    logic [9:0]  if_addr4;
    logic [31:0] if_rdata4;
    logic        if_done4;
    logic [31:0] dm_rdata4;
    logic        dm_done4;
    logic        mem_en4;
    logic        mem_we4;
    logic [9:0]  mem_addr4;
    logic [31:0] mem_wdata4;
    logic [31:0] mem_rdata4;
    logic        busy4;
    logic        proto_err4;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   we_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;

    bit   [31:0] mem [1024];
    logic [31:0] rd_pipe;
    logic [31:0] p4_0, p4_1, p4_2;

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .proto_err(proto_err)
    );

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_done(if_done1),
        .dm_rd(1'b0), .dm_wr(1'b0), .dm_addr(10'd0), .dm_wdata(32'd0),
        .dm_rdata(dm_rdata1), .dm_done(dm_done1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1), .proto_err(proto_err1)
    );

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(4)) dut_lat4 (
        .clk(clk), .rst(rst),
        .if_req(if_req4), .if_addr(if_addr4), .if_rdata(if_rdata4), .if_done(if_done4),
        .dm_rd(1'b0), .dm_wr(1'b0), .dm_addr(10'd0), .dm_wdata(32'd0),
        .dm_rdata(dm_rdata4), .dm_done(dm_done4),
        .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .mem_rdata(mem_rdata4), .busy(busy4), .proto_err(proto_err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Main memory: data is presented exactly one cycle after the mem_en cycle.
    always @(posedge clk) begin
        if (cyc == 0) begin
            mem[4] <= 32'hDEADBEEF;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        rd_pipe <= (mem_en && !mem_we) ? mem[mem_addr] : 32'd0;
    end
    assign mem_rdata = rd_pipe;

    // Latency-sweep memories return 0xA5000000 | address.
    assign mem_rdata1 = (mem_en1 && !mem_we1) ? (32'hA5000000 | {22'd0, mem_addr1}) : 32'd0;

    always @(posedge clk) begin
        p4_0 <= (mem_en4 && !mem_we4) ? (32'hA5000000 | {22'd0, mem_addr4}) : 32'd0;
        p4_1 <= p4_0;
        p4_2 <= p4_1;
    end
    assign mem_rdata4 = p4_2;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic f, input logic rd, input logic wr,
                                 input logic [9:0] fa, input logic [9:0] da,
                                 input logic [31:0] wd);
        if_req   = f;
        if_addr  = fa;
        dm_rd    = rd;
        dm_wr    = wr;
        dm_addr  = da;
        dm_wdata = wd;
    endtask

    task automatic expectDone(input logic req, input logic [31:0] data, input logic chk, input int at);
        exp_t e;
        e.req  = req;
        e.data = data;
        e.chk  = chk;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tickTo(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic waitDoneRelease(input int budget);
        int k = 0;
        while (!(if_done || dm_done) && k < budget) begin
            tick(1);
            k++;
        end
        if (!(if_done || dm_done)) begin
            total++;
            bad++;
            $display("[TB] FAIL done_timeout: got=no done expected=done within %0d cycles", budget);
        end
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (if_done || dm_done)) begin
            if (if_done && dm_done) begin
                total++;
                bad++;
                $display("[TB] FAIL both_done: got=both done pulses expected=one (cycle %0d)", cyc);
            end else if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done: got=done req=%0d expected=none (cycle %0d)", dm_done, cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("done_requester", {31'd0, dm_done}, {31'd0, mon_e.req});
                checkOutput("done_cycle", cyc, mon_e.at);
                if (mon_e.chk) begin
                    checkOutput("done_rdata", dm_done ? dm_rdata : if_rdata, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int we0;
        int d1;
        int d4;
        logic [31:0] r1;
        logic [31:0] r4;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 32'd0);
        if_req1 = 1'b0; if_addr1 = 10'd0;
        if_req4 = 1'b0; if_addr4 = 10'd0;
        tick(3);

        checkOutput("rst_mem", {mem_en, mem_we, 20'd0, mem_addr}, 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        checkOutput("rst_rdata", if_rdata | dm_rdata, 32'd0);
        checkOutput("rst_flags", {28'd0, if_done, dm_done, busy, proto_err}, 32'd0);
        rst = 1'b0;

        // Lone fetch at cycle 10.
        tickTo(10);
        n = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 10'h004, 10'd0, 32'd0);
        expectDone(1'b0, 32'hDEADBEEF, 1'b1, n + 3);
        tick(1);
        checkOutput("fetch_mem_en", {31'd0, mem_en}, 32'd1);
        checkOutput("fetch_mem_addr", {22'd0, mem_addr}, 32'h004);
        checkOutput("fetch_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("fetch_busy_n1", {31'd0, busy}, 32'd1);
        tick(1);
        checkOutput("fetch_en_once", {31'd0, mem_en}, 32'd0);
        checkOutput("fetch_busy_n2", {31'd0, busy}, 32'd1);
        tick(1);
        checkOutput("fetch_busy_n3", {31'd0, busy}, 32'd1);
        tick(1);
        checkOutput("fetch_busy_n4", {31'd0, busy}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 32'd0);

        // Lone store then read-back.
        we0 = we_cnt;
        n = cyc;
        applyStimulus(1'b0, 1'b0, 1'b1, 10'd0, 10'h020, 32'h12345678);
        expectDone(1'b1, 32'd0, 1'b0, n + 2);
        tick(1);
        checkOutput("store_we", {30'd0, mem_en, mem_we}, 32'd3);
        checkOutput("store_addr", {22'd0, mem_addr}, 32'h020);
        checkOutput("store_wdata", mem_wdata, 32'h12345678);
        tick(1);
        checkOutput("store_we_once", {31'd0, mem_we}, 32'd0);
        tickTo(n + 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 32'd0);
        checkOutput("store_we_count", we_cnt - we0, 32'd1);
        n = cyc;
        applyStimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'h020, 32'd0);
        expectDone(1'b1, 32'h12345678, 1'b1, n + 3);
        waitDoneRelease(10);

        // Two collisions in a row: fetch is granted first both times.
        for (int r = 0; r < 2; r++) begin
            tick(1);
            n = cyc;
            applyStimulus(1'b1, 1'b1, 1'b0, 10'h004, 10'h020, 32'd0);
            expectDone(1'b0, 32'hDEADBEEF, 1'b1, n + 3);
            expectDone(1'b1, 32'h12345678, 1'b1, n + 7);
            tickTo(n + 4);
            if_req = 1'b0;
            tickTo(n + 8);
            dm_rd = 1'b0;
        end

        // Read and write together: treated as a write, sticky error.
        checkOutput("proto_err_clear", {31'd0, proto_err}, 32'd0);
        n = cyc;
        applyStimulus(1'b0, 1'b1, 1'b1, 10'd0, 10'h030, 32'hCAFEF00D);
        expectDone(1'b1, 32'd0, 1'b0, n + 2);
        tick(1);
        checkOutput("proto_we", {31'd0, mem_we}, 32'd1);
        tickTo(n + 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 32'd0);
        checkOutput("proto_err_set", {31'd0, proto_err}, 32'd1);
        n = cyc;
        applyStimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'h030, 32'd0);
        expectDone(1'b1, 32'hCAFEF00D, 1'b1, n + 3);
        waitDoneRelease(10);
        checkOutput("proto_err_sticky", {31'd0, proto_err}, 32'd1);

        // Fetch request withdrawn during WAIT still completes.
        n = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 10'h004, 10'd0, 32'd0);
        expectDone(1'b0, 32'hDEADBEEF, 1'b1, n + 3);
        tickTo(n + 2);
        if_req = 1'b0;
        tickTo(n + 4);
        checkOutput("withdraw_idle", {31'd0, busy}, 32'd0);
        checkOutput("dm_rdata_hold", dm_rdata, 32'hCAFEF00D);

        // Reset in the middle of a read abandons it.
        tick(1);
        n = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 10'h020, 10'd0, 32'd0);
        tickTo(n + 2);
        checkOutput("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_mem", {mem_en, mem_we, 20'd0, mem_addr}, 32'd0);
        checkOutput("async_rst_wdata", mem_wdata, 32'd0);
        checkOutput("async_rst_rdata", if_rdata | dm_rdata, 32'd0);
        checkOutput("async_rst_flags", {28'd0, if_done, dm_done, busy, proto_err}, 32'd0);
        if_req = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(3);
        checkOutput("post_rst_idle", {30'd0, busy, mem_en}, 32'd0);
        n = cyc;
        applyStimulus(1'b1, 1'b1, 1'b0, 10'h004, 10'h030, 32'd0);
        expectDone(1'b0, 32'hDEADBEEF, 1'b1, n + 3);
        expectDone(1'b1, 32'hCAFEF00D, 1'b1, n + 7);
        tickTo(n + 4);
        if_req = 1'b0;
        tickTo(n + 8);
        dm_rd = 1'b0;

        // Read latency sweep on the RD_LAT=1 and RD_LAT=4 instances.
        tick(1);
        if_addr1 = 10'h011;
        if_addr4 = 10'h044;
        if_req1  = 1'b1;
        if_req4  = 1'b1;
        n  = cyc;
        d1 = -1;
        d4 = -1;
        r1 = 32'd0;
        r4 = 32'd0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (d1 >= 0 && cyc == d1 + 1) if_req1 = 1'b0;
            if (d4 >= 0 && cyc == d4 + 1) if_req4 = 1'b0;
            if (if_done1 && d1 < 0) begin
                d1 = cyc;
                r1 = if_rdata1;
            end
            if (if_done4 && d4 < 0) begin
                d4 = cyc;
                r4 = if_rdata4;
            end
        end
        if_req1 = 1'b0;
        if_req4 = 1'b0;
        checkOutput("lat1_done_cycle", d1, n + 2);
        checkOutput("lat1_rdata", r1, 32'hA5000011);
        checkOutput("lat4_done_cycle", d4, n + 5);
        checkOutput("lat4_rdata", r4, 32'hA5000044);
        checkOutput("lat1_quiet", {27'd0, busy1, dm_done1, proto_err1, mem_we1, |(mem_wdata1 | dm_rdata1)}, 32'd0);
        checkOutput("lat4_quiet", {27'd0, busy4, dm_done4, proto_err4, mem_we4, |(mem_wdata4 | dm_rdata4)}, 32'd0);

        tick(2);
        checkOutput("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
